// File: rtl/alu_operand_loader_if.sv
// Byte-stream input and operand-set output handshakes of the ALU operand loader.
// The slave side is the loader; the master side is its feeder/consumer.
`timescale 1ns/1ps
interface alu_operand_loader_if;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A0;
  logic [7:0] B0;
  logic [7:0] A1;
  logic [7:0] B1;
  logic [1:0] ALU_Sel1;
  logic [1:0] ALU_Sel2;
  logic       op_valid;
  logic       op_ready;

  modport master (
    output in_data, in_sof, in_valid, op_ready,
    input  in_ready, A0, B0, A1, B1, ALU_Sel1, ALU_Sel2, op_valid
  );

  modport slave (
    input  in_data, in_sof, in_valid, op_ready,
    output in_ready, A0, B0, A1, B1, ALU_Sel1, ALU_Sel2, op_valid
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects 5-byte operand frames into shadow registers and presents the
// complete operand set with a valid/ready handshake plus sticky error flags.
`timescale 1ns/1ps
module alu_operand_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  alu_operand_loader_if.slave bus,
  input  logic               clr_status,
  output logic               err_sel,
  output logic               err_timeout,
  output logic               err_resync,
  output logic [CNT_W-1:0]   frame_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic [2:0]       idx_reg;
  logic [15:0]      tmo_reg;
  logic [31:0]      ops_reg;
  logic [1:0]       sel1_reg;
  logic [1:0]       sel2_reg;
  logic             in_ready_reg;
  logic             op_valid_reg;
  logic             err_sel_reg;
  logic             err_timeout_reg;
  logic             err_resync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      shadow_bytes;
  logic [3:0]       wr_en;
  logic             accept;

  assign accept = bus.in_valid && in_ready_reg;

  // A start-of-frame byte always lands in slot 0, even as a mid-frame restart.
  always_comb begin
    wr_en = '0;
    if (accept && state_reg != PRESENT) begin
      if (bus.in_sof) begin
        wr_en[0] = 1'b1;
      end else if (state_reg == COLLECT && idx_reg < 3'd4) begin
        wr_en[idx_reg[1:0]] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shadow
      logic [7:0] byte_reg;
      always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= '0;
        end else if (wr_en[gi]) begin
          byte_reg <= bus.in_data;
        end
      end
      assign shadow_bytes[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      tmo_reg         <= '0;
      ops_reg         <= '0;
      sel1_reg        <= '0;
      sel2_reg        <= '0;
      in_ready_reg    <= 1'b1;
      op_valid_reg    <= 1'b0;
      err_sel_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_resync_reg  <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      // Clear first so a same-cycle set event below takes priority.
      if (clr_status) begin
        err_sel_reg     <= 1'b0;
        err_timeout_reg <= 1'b0;
        err_resync_reg  <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.in_sof) begin
              idx_reg   <= 3'd1;
              tmo_reg   <= '0;
              state_reg <= COLLECT;
            end else begin
              err_resync_reg <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            tmo_reg <= '0;
            if (bus.in_sof) begin
              err_resync_reg <= 1'b1;
              idx_reg        <= 3'd1;
            end else if (idx_reg == 3'd4) begin
              idx_reg <= '0;
              if (bus.in_data[7:4] != 4'd0) begin
                err_sel_reg <= 1'b1;
                state_reg   <= IDLE;
              end else begin
                ops_reg      <= shadow_bytes;
                sel1_reg     <= bus.in_data[1:0];
                sel2_reg     <= bus.in_data[3:2];
                op_valid_reg <= 1'b1;
                in_ready_reg <= 1'b0;
                state_reg    <= PRESENT;
              end
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else if (tmo_reg == TMO_LAST) begin
            err_timeout_reg <= 1'b1;
            tmo_reg         <= '0;
            idx_reg         <= '0;
            state_reg       <= IDLE;
          end else begin
            tmo_reg <= tmo_reg + 16'd1;
          end
        end
        PRESENT: begin
          if (op_valid_reg && bus.op_ready) begin
            op_valid_reg <= 1'b0;
            in_ready_reg <= 1'b1;
            cnt_reg      <= cnt_reg + CNT_W'(1);
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.op_valid  = op_valid_reg;
  assign bus.A0        = ops_reg[7:0];
  assign bus.B0        = ops_reg[15:8];
  assign bus.A1        = ops_reg[23:16];
  assign bus.B1        = ops_reg[31:24];
  assign bus.ALU_Sel1  = sel1_reg;
  assign bus.ALU_Sel2  = sel2_reg;
  assign err_sel       = err_sel_reg;
  assign err_timeout   = err_timeout_reg;
  assign err_resync    = err_resync_reg;
  assign frame_cnt     = cnt_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: expected operand sets are queued as
// frames are driven and compared when the loader hands them over.
`timescale 1ns/1ps
module tb_alu_operand_loader;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_status = 1'b0;
  logic             err_sel;
  logic             err_timeout;
  logic             err_resync;
  logic [CNT_W-1:0] frame_cnt;

  alu_operand_loader_if bif();

  alu_operand_loader #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .wb_clk_i   (clk),
    .rst_n      (rst_n),
    .bus        (bif.slave),
    .clr_status (clr_status),
    .err_sel    (err_sel),
    .err_timeout(err_timeout),
    .err_resync (err_resync),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  logic [35:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] obs_set();
    return {bif.ALU_Sel2, bif.ALU_Sel1, bif.B1, bif.A1, bif.B0, bif.A0};
  endfunction

  // Handshake completes on the following rising edge; compare here.
  always @(negedge clk) begin
    if (rst_n && bif.op_valid && bif.op_ready) begin
      logic [63:0] exp;
      exp = (sb.size() > 0) ? {28'd0, sb.pop_front()} : 64'h10_0000_0000;
      check("opset", {28'd0, obs_set()}, exp);
      delivered++;
      $display("op_set %0d: A0=%02h B0=%02h A1=%02h B1=%02h sel1=%0d sel2=%0d",
               delivered, bif.A0, bif.B0, bif.A1, bif.B1, bif.ALU_Sel1, bif.ALU_Sel2);
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sof);
    int n = 0;
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    bif.in_sof   = sof;
    while (!bif.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_wait", {63'd0, bif.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    bif.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1,
                            input logic [7:0] b1, input logic [7:0] sel);
    if (sel[7:4] == 4'd0) sb.push_back({sel[3:2], sel[1:0], b1, a1, b0, a0});
    send_byte(a0, 1'b1);
    send_byte(b0, 1'b0);
    send_byte(a1, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(sel, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) check("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.in_valid = 1'b0;
    bif.in_sof   = 1'b0;
    bif.in_data  = 8'h00;
    bif.op_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_opset", {28'd0, obs_set()}, 64'd0);
    check("rst_op_valid", {63'd0, bif.op_valid}, 64'd0);
    check("rst_err", {61'd0, err_sel, err_timeout, err_resync}, 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_in_ready", {63'd0, bif.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h09);
    check("nom_op_valid_latency", {63'd0, bif.op_valid}, 64'd1);
    check("nom_sel", {60'd0, bif.ALU_Sel2, bif.ALU_Sel1}, 64'h9);
    wait_drain();
    check("nom_frame_cnt", 64'(frame_cnt), 64'd1);
    check("nom_err", {61'd0, err_sel, err_timeout, err_resync}, 64'd0);
    check("nom_in_ready", {63'd0, bif.in_ready}, 64'd1);

    // Backpressure
    @(posedge clk);
    #1;
    bif.op_ready = 1'b0;
    send_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h06);
    repeat (10) begin
      @(negedge clk);
      check("bp_op_valid", {63'd0, bif.op_valid}, 64'd1);
      check("bp_in_ready", {63'd0, bif.in_ready}, 64'd0);
      check("bp_hold", {28'd0, obs_set()}, {28'd0, 2'b01, 2'b10, 8'hD4, 8'hC3, 8'hB2, 8'hA1});
    end
    check("bp_frame_cnt_held", 64'(frame_cnt), 64'd1);
    @(posedge clk);
    #1;
    bif.op_ready = 1'b1;
    wait_drain();
    check("bp_frame_cnt", 64'(frame_cnt), 64'd2);

    // Bad select byte
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h35);
    check("sel_err", {63'd0, err_sel}, 64'd1);
    check("sel_op_valid", {63'd0, bif.op_valid}, 64'd0);
    check("sel_outputs_kept", {28'd0, obs_set()}, {28'd0, 2'b01, 2'b10, 8'hD4, 8'hC3, 8'hB2, 8'hA1});
    repeat (3) @(negedge clk);
    check("sel_frame_cnt", 64'(frame_cnt), 64'd2);
    pulse_clr();
    check("sel_clr", {63'd0, err_sel}, 64'd0);

    // Stray byte in IDLE coinciding with clr_status: set wins
    @(negedge clk);
    clr_status   = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_sof   = 1'b0;
    bif.in_data  = 8'h55;
    @(posedge clk);
    #1;
    clr_status   = 1'b0;
    bif.in_valid = 1'b0;
    check("set_wins_resync", {63'd0, err_resync}, 64'd1);
    pulse_clr();
    check("resync_clr", {63'd0, err_resync}, 64'd0);

    // Resync on sof mid-frame
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    check("resync_err", {63'd0, err_resync}, 64'd1);
    wait_drain();
    check("resync_A0", 64'(bif.A0), 64'h01);
    check("resync_B1", 64'(bif.B1), 64'h04);
    check("resync_frame_cnt", 64'(frame_cnt), 64'd3);
    pulse_clr();

    // Timeout after 4 idle cycles
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("tmo_not_yet", {63'd0, err_timeout}, 64'd0);
    @(posedge clk);
    #1;
    check("tmo_err", {63'd0, err_timeout}, 64'd1);
    check("tmo_in_ready", {63'd0, bif.in_ready}, 64'd1);
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F);
    wait_drain();
    check("tmo_frame_cnt", 64'(frame_cnt), 64'd4);
    check("tmo_resync_clean", {63'd0, err_resync}, 64'd0);

    // Asynchronous reset mid-frame
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_opset", {28'd0, obs_set()}, 64'd0);
    check("arst_err", {61'd0, err_sel, err_timeout, err_resync}, 64'd0);
    check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("arst_op_valid", {63'd0, bif.op_valid}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // 256 frames from reset wrap the counter
    for (int i = 0; i < 256; i++) begin
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom_range(0, 15)));
    end
    wait_drain();
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
    check("wrap_err", {61'd0, err_sel, err_timeout, err_resync}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
